ct_spsram_1024x32_ctrl: RTL and testbench
=========================================

// Module: ct_spsram_1024x32_ctrl
// PURPOSE
//   Initiator for a 1024x32 single-port SRAM (active-low CEN/GWEN/bit-WEN, 1-cycle read latency).
//   Accepts valid/ready read/write requests with byte enables, drives the SRAM pins and returns read data
//   through a credit-protected response FIFO. After reset it optionally clears the whole array.
//   Sits between LSU-side request logic and the SRAM wrapper; all SRAM-side outputs go straight to the macro.
// PARAMETERS
//   ADDR_WIDTH  10            SRAM address width (depth = 2**ADDR_WIDTH)
//   DATA_WIDTH  32            data width; byte lanes = DATA_WIDTH/8
//   RSP_DEPTH   4             response FIFO entries (>=2); 4 gives 1 read/cycle sustained
//   INIT_EN     1             1: clear array after reset; 0: go straight to RUN
//   INIT_VALUE  32'h0         data written to every entry during init
// PORTS
//   forever_cpuclk  in   1            clock; SRAM CLK is the same clock
//   cpurst          in   1            synchronous, active-high reset
//   req_vld         in   1            request valid
//   req_ready       out  1            request accepted when req_vld & req_ready
//   req_wr          in   1            1 write, 0 read
//   req_addr        in   ADDR_WIDTH   word address
//   req_wdata       in   DATA_WIDTH   write data
//   req_wbe         in   DATA_WIDTH/8  byte enables, active-high (write only)
//   rsp_vld         out  1            read data valid (head of FIFO)
//   rsp_ready       in   1            consumer takes rsp_rdata when rsp_vld & rsp_ready
//   rsp_rdata       out  DATA_WIDTH   read data
//   init_done       out  1            high once state==RUN
//   sram_a          out  ADDR_WIDTH   to SRAM A
//   sram_cen        out  1            to SRAM CEN, active-low
//   sram_gwen       out  1            to SRAM GWEN, active-low (0 = write)
//   sram_wen        out  DATA_WIDTH   to SRAM WEN, per-bit active-low
//   sram_d          out  DATA_WIDTH   to SRAM D
//   sram_q          in   DATA_WIDTH   from SRAM Q, valid the cycle after a read access
// BEHAVIOUR
// - Reset (cpurst=1 at a clock edge): state=INIT (INIT_EN=1) else RUN; init_cnt=0; FIFO empty; rd_inflight=0.
//   Outputs during/after reset cycle: req_ready=0, rsp_vld=0, init_done=INIT_EN?0:1, sram_cen=1, sram_gwen=1,
//   sram_wen=all 1, sram_a=0, sram_d=0. Reset mid-init or mid-traffic discards FIFO/inflight, restarts init at 0.
// - FSM INIT: each cycle sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_a=init_cnt, sram_d=INIT_VALUE; init_cnt++.
//   At init_cnt==2**ADDR_WIDTH-1 the write is issued and next state=RUN (exactly 2**ADDR_WIDTH cycles). req_ready=0.
// - FSM RUN: terminal until reset. used = fifo_cnt + rd_inflight (registered values).
//   req_ready = (state==RUN) & (used < RSP_DEPTH); independent of req_wr and rsp_ready.
// - Accepted write (fire & req_wr): same cycle sram_cen=0, sram_gwen=0, sram_a=req_addr, sram_d=req_wdata,
//   sram_wen[8i+7:8i] = {8{~req_wbe[i]}}. req_wbe==0 still issues the access (no bits written).
// - Accepted read (fire & ~req_wr): same cycle sram_cen=0, sram_gwen=1, sram_wen=all 1, sram_a=req_addr;
//   rd_inflight<=1 for next cycle, else 0. Cycle with rd_inflight=1: sram_q pushed into FIFO tail.
// - Idle RUN cycle (no fire): sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0.
// - Read latency: request accepted cycle t -> rsp_vld no earlier than t+2 with that data; responses in order.
// - FIFO: rsp_vld = fifo_cnt!=0; rsp_rdata = head (registered). Push and pop same cycle: cnt unchanged.
//   Push when full cannot occur (credit rule); assertion required. Pointers wrap modulo RSP_DEPTH.
// - Read-after-write to same address on consecutive cycles returns the new data (SRAM ordering; no bypass).
// - Write data while rsp path is full: writes also stall (uniform ready) — accepted simplification.
// TESTING
// - Reset, INIT_EN=1: init_done rises exactly 1024 cycles after reset release; then read addr 5 -> rsp_rdata=32'h0.
// - Write addr 10 data 32'hDEAD_BEEF wbe 4'hF, then write addr 10 data 32'h1122_3344 wbe 4'b0101, read 10
//   -> rsp_rdata=32'hDE22_BE44; sram_wen for 2nd write = 32'hFF00_FF00.
// - 64 back-to-back reads, rsp_ready=1 -> req_ready never drops, 64 responses, first at t+2, in order.
// - rsp_ready=0, issue reads: exactly RSP_DEPTH accepted, req_ready=0 after; rsp_ready=1 -> all drain in order.
// - Assert cpurst at init_cnt=300 with pending FIFO data -> rsp_vld=0 next cycle, init restarts at sram_a=0.
// - Random wr/rd/backpressure vs reference memory model; FIFO-overflow and ready-when-INIT assertions never fire.

Source files
------------

// File: rtl/ct_spsram_1024x32_ctrl.sv
// Valid/ready initiator for a single-port SRAM macro with post-reset array clear
// and a credit-protected read response FIFO.
module ct_spsram_1024x32_ctrl #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RSP_DEPTH  = 4,
    parameter int unsigned INIT_EN    = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst,
    input  logic                    req_vld,
    output logic                    req_ready,
    input  logic                    req_wr,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wbe,
    output logic                    rsp_vld,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    init_done,
    output logic [ADDR_WIDTH-1:0]   sram_a,
    output logic                    sram_cen,
    output logic                    sram_gwen,
    output logic [DATA_WIDTH-1:0]   sram_wen,
    output logic [DATA_WIDTH-1:0]   sram_d,
    input  logic [DATA_WIDTH-1:0]   sram_q
);

    localparam int unsigned NBYTE = DATA_WIDTH / 8;
    localparam int unsigned PW    = $clog2(RSP_DEPTH);
    localparam int unsigned CW    = $clog2(RSP_DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(RSP_DEPTH - 1);
    localparam logic [CW:0]   DEPTH_L  = (CW+1)'(RSP_DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(RSP_DEPTH);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   init_cnt;
    logic [DATA_WIDTH-1:0]   fifo_mem [RSP_DEPTH];
    logic [PW-1:0]           wptr, rptr;
    logic [CW-1:0]           fifo_cnt;
    logic                    rd_inflight;
    logic [CW:0]             used;
    logic                    fire, push, pop;

    // A read in flight already owns a FIFO slot, so it counts against the credit.
    assign used = {1'b0, fifo_cnt} + {{CW{1'b0}}, rd_inflight};
    assign fire = req_vld & req_ready;
    assign push = rd_inflight;
    assign pop  = rsp_vld & rsp_ready;

    assign rsp_vld   = ~cpurst & (fifo_cnt != '0);
    assign rsp_rdata = fifo_mem[rptr];

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q  <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
            init_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT)
                init_cnt <= init_cnt + 1'b1;
        end
    end

    // Reset holds the macro pins idle combinationally, even while state is INIT.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        init_done = (state_q == ST_RUN);
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        if (cpurst) begin
            init_done = (INIT_EN == 0);
        end else begin
            case (state_q)
                ST_INIT: begin
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_wen  = '0;
                    sram_a    = init_cnt;
                    sram_d    = INIT_VALUE;
                    if (&init_cnt)
                        state_d = ST_RUN;
                end
                ST_RUN: begin
                    req_ready = (used < DEPTH_L);
                    if (req_vld && req_ready) begin
                        sram_cen = 1'b0;
                        sram_a   = req_addr;
                        if (req_wr) begin
                            sram_gwen = 1'b0;
                            sram_d    = req_wdata;
                            for (int unsigned i = 0; i < NBYTE; i++)
                                sram_wen[8*i +: 8] = {8{~req_wbe[i]}};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            wptr        <= '0;
            rptr        <= '0;
            fifo_cnt    <= '0;
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= fire & ~req_wr;
            if (push)
                wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
            if (pop)
                rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
            if (push && !pop)
                fifo_cnt <= fifo_cnt + 1'b1;
            else if (pop && !push)
                fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst && push)
            fifo_mem[wptr] <= sram_q;
    end

    a_fifo_no_overflow: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
        !(push && !pop && fifo_cnt == FULL_CNT));

    a_no_ready_in_init: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
        !(state_q == ST_INIT && req_ready));

endmodule

// File: tb/tb_ct_spsram_1024x32_ctrl.sv
// Directed bench for ct_spsram_1024x32_ctrl with a behavioural SRAM macro and reference memory.
module tb_ct_spsram_1024x32_ctrl;

    logic        clk = 1'b0;
    logic        cpurst;
    logic        req_vld, req_ready, req_wr;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wbe;
    logic        rsp_vld, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        init_done;
    logic [9:0]  sram_a;
    logic        sram_cen, sram_gwen;
    logic [31:0] sram_wen, sram_d, sram_q;

    always #5 clk = ~clk;

    ct_spsram_1024x32_ctrl #(
        .ADDR_WIDTH(10), .DATA_WIDTH(32), .RSP_DEPTH(4), .INIT_EN(1), .INIT_VALUE(32'h0)
    ) dut (
        .forever_cpuclk(clk), .cpurst(cpurst),
        .req_vld(req_vld), .req_ready(req_ready), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wbe(req_wbe),
        .rsp_vld(rsp_vld), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .init_done(init_done),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
        .sram_d(sram_d), .sram_q(sram_q)
    );

    // Macro model: per-bit active-low write mask, Q registered one cycle after a read.
    logic [31:0] sram_mem [1024];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen)
                sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else
                sram_q <= sram_mem[sram_a];
        end
    end

    logic [31:0] ref_mem [1024];
    logic [31:0] expq [$];
    int          nvec = 0, nerr = 0, cyc = 0;
    int          nfire, npop, drops, first_fire, first_rsp, k;
    logic [31:0] last_wen, last_rsp;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        logic        f, p;
        logic [31:0] ew;
        @(negedge clk);
        f = req_vld & req_ready;
        p = rsp_vld & rsp_ready;
        if (req_vld && !req_ready && init_done) drops++;
        if (rsp_vld && first_rsp < 0) first_rsp = cyc;
        if (p) begin
            npop++;
            last_rsp = rsp_rdata;
            if (expq.size() == 0) check("rsp_extra", 32'(expq.size()), 1);
            else check("rsp_data", rsp_rdata, expq.pop_front());
        end
        if (f) begin
            nfire++;
            if (first_fire < 0) first_fire = cyc;
            check("fire_cen", 32'(sram_cen), 0);
            check("fire_a", 32'(sram_a), 32'(req_addr));
            if (req_wr) begin
                for (int b = 0; b < 4; b++) ew[8*b +: 8] = req_wbe[b] ? 8'h00 : 8'hFF;
                check("wr_gwen", 32'(sram_gwen), 0);
                check("wr_wen", sram_wen, ew);
                check("wr_d", sram_d, req_wdata);
                last_wen = sram_wen;
                for (int b = 0; b < 4; b++)
                    if (req_wbe[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
            end else begin
                check("rd_gwen", 32'(sram_gwen), 1);
                check("rd_wen", sram_wen, 32'hFFFF_FFFF);
                expq.push_back(ref_mem[req_addr]);
            end
        end else if (init_done && !cpurst) begin
            check("idle_cen", 32'(sram_cen), 1);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain();
        req_vld   = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 50 && (expq.size() > 0 || rsp_vld); i++) tick();
        check("drain_empty", 32'(expq.size()), 0);
    endtask

    // Waits for init_done starting from init cycle k0; returns the cycle index where it rose.
    task automatic wait_init(input int k0, output int kr);
        for (kr = k0; kr < 2000; kr++) begin
            @(negedge clk);
            if (init_done) break;
            if (kr == k0 || kr == 1023) begin
                check("init_a", 32'(sram_a), 32'(kr));
                check("init_cen", 32'(sram_cen), 0);
                check("init_ready", 32'(req_ready), 0);
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    endtask

    initial begin
        cpurst = 1'b1; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0;
        req_wdata = '0; req_wbe = '0; rsp_ready = 1'b1;
        nfire = 0; npop = 0; drops = 0; first_fire = -1; first_rsp = -1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_vld", 32'(rsp_vld), 0);
        check("rst_init_done", 32'(init_done), 0);
        check("rst_cen", 32'(sram_cen), 1);
        check("rst_gwen", 32'(sram_gwen), 1);
        check("rst_wen", sram_wen, 32'hFFFF_FFFF);
        check("rst_a", 32'(sram_a), 0);
        check("rst_d", sram_d, 32'h0);
        @(posedge clk);
        #1;
        cpurst = 1'b0;
        wait_init(0, k);
        check("init_len", 32'(k), 1024);

        // Read of a cleared word.
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 10'd5;
        tick();
        drain();
        check("rd5_data", last_rsp, 32'h0);

        // Partial-byte overwrite then immediate read.
        req_vld = 1'b1; req_wr = 1'b1; req_addr = 10'd10; req_wdata = 32'hDEAD_BEEF; req_wbe = 4'hF;
        tick();
        req_wdata = 32'h1122_3344; req_wbe = 4'b0101;
        tick();
        check("wen_partial", last_wen, 32'hFF00_FF00);
        req_wr = 1'b0;
        tick();
        drain();
        check("rd10_merge", last_rsp, 32'hDE22_BE44);

        // Back-to-back reads at full rate.
        req_vld = 1'b1; req_wr = 1'b1; req_wbe = 4'hF;
        for (int i = 0; i < 64; i++) begin
            req_addr  = 10'(100 + i);
            req_wdata = (32'h0101_0101 * i) ^ 32'hA5A5_0000;
            tick();
        end
        req_wr = 1'b0; drops = 0; npop = 0; first_fire = -1; first_rsp = -1;
        for (int i = 0; i < 64; i++) begin
            req_addr = 10'(100 + i);
            tick();
        end
        drain();
        check("b2b_rsps", 32'(npop), 64);
        check("b2b_drops", 32'(drops), 0);
        check("b2b_latency", 32'(first_rsp - first_fire), 2);

        // Backpressured responses: credit limits acceptance to the FIFO depth.
        nfire = 0; rsp_ready = 1'b0; req_vld = 1'b1; req_wr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_addr = 10'(100 + 3 * i);
            tick();
        end
        check("bp_accepted", 32'(nfire), 4);
        check("bp_ready_low", 32'(req_ready), 0);
        drain();

        // Random traffic against the reference memory.
        for (int i = 0; i < 300; i++) begin
            req_vld   = ($urandom_range(0, 3) != 0);
            req_wr    = $urandom_range(0, 1) == 1;
            req_addr  = 10'($urandom_range(0, 15));
            req_wdata = $urandom;
            req_wbe   = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Reset with responses pending, then reset again partway through init.
        rsp_ready = 1'b0; req_vld = 1'b1; req_wr = 1'b0; req_addr = 10'd10;
        repeat (4) tick();
        req_vld = 1'b0;
        tick();
        check("pend_rsp_vld", 32'(rsp_vld), 1);
        cpurst = 1'b1;
        @(negedge clk);
        check("rst2_rsp_vld", 32'(rsp_vld), 0);
        check("rst2_cen", 32'(sram_cen), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst2_rsp_vld_after", 32'(rsp_vld), 0);
        @(posedge clk);
        #1;
        cpurst = 1'b0;
        expq.delete();
        rsp_ready = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_init_a", 32'(sram_a), 300);
        cpurst = 1'b1;
        #1;
        check("mid_rst_cen", 32'(sram_cen), 1);
        check("mid_rst_rsp_vld", 32'(rsp_vld), 0);
        @(posedge clk);
        #1;
        cpurst = 1'b0;
        @(negedge clk);
        check("restart_a", 32'(sram_a), 0);
        check("restart_cen", 32'(sram_cen), 0);
        check("restart_init_done", 32'(init_done), 0);
        @(posedge clk);
        #1;
        wait_init(1, k);
        check("reinit_len", 32'(k), 1024);

        // Previously written word must be cleared by the re-init.
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 10'd10;
        tick();
        drain();
        check("rd10_cleared", last_rsp, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
